// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves conditional branches against registered ALU flags,
// supplies absolute jump targets from a programmable LUT to the PC, squashes
// the wrong-path instruction after a taken branch and detects branch-to-self
// as program halt.
module branch_ctrl #(
    parameter int unsigned D = 8,   // PC / target width
    parameter int unsigned L = 4,   // target-LUT index width
    parameter int unsigned C = 16   // taken-branch counter width
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    input  logic         br_valid,
    input  logic [1:0]   br_cond,
    input  logic [L-1:0] br_idx,
    input  logic         flag_we,
    input  logic         zero_in,
    input  logic         neg_in,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic         branch,
    output logic [D-1:0] target,
    output logic         flush,
    output logic         halt,
    output logic [C-1:0] taken_cnt
);

    localparam int unsigned DEPTH = 2 ** L;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SHADOW = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   lut_q [DEPTH];
    logic           zero_q, neg_q;
    logic           flush_q, flush_d;
    logic           halt_q, halt_d;
    logic [C-1:0]   cnt_q, cnt_d;

    logic [D-1:0]   lut_rd;
    logic           z_eff, n_eff;
    logic           cond_ok;
    logic           take;
    logic           self_br;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [C-1:0] sat_inc(input logic [C-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(C-1){1'b0}}, 1'b1};
    endfunction

    // Combinational LUT read; a same-cycle write is not visible until the next cycle.
    assign lut_rd = lut_q[br_idx];

    // A flag update in this cycle bypasses the flag registers.
    assign z_eff = flag_we ? zero_in : zero_q;
    assign n_eff = flag_we ? neg_in  : neg_q;

    // Condition code decode on the bypassed flags.
    always_comb begin
        cond_ok = 1'b0;
        case (br_cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = z_eff;
            2'b10:   cond_ok = ~z_eff;
            2'b11:   cond_ok = n_eff;
            default: cond_ok = 1'b0;
        endcase
    end

    // Only RUN may take a branch; SHADOW and HALT ignore br_valid.
    assign take    = br_valid & cond_ok & (state_q == ST_RUN);
    assign self_br = (lut_rd == prog_ctr);

    // Target LUT: cleared on reset, written on lut_we.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    // ALU flag registers, loaded on flag_we in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (flag_we) begin
            zero_q <= zero_in;
            neg_q  <= neg_in;
        end
    end

    // FSM state register plus registered flush/halt/counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a taken branch opens a one-cycle shadow, branch-to-self halts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (take) begin
                    state_d = self_br ? ST_HALT : ST_SHADOW;
                end
            end
            ST_SHADOW: state_d = ST_RUN;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RUN;
        endcase
    end

    // Output logic: PC load request, target select and next values of registered outputs.
    always_comb begin
        branch  = 1'b0;
        target  = lut_rd;
        flush_d = (state_d != ST_RUN);
        halt_d  = (state_d == ST_HALT);
        cnt_d   = take ? sat_inc(cnt_q) : cnt_q;
        if (state_q == ST_HALT) begin
            // Reload the current PC forever so the program counter freezes.
            branch = ~reset;
            target = prog_ctr;
        end else begin
            branch = take & ~reset;
        end
    end

    assign flush     = flush_q;
    assign halt      = halt_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: one default instance plus a C=2 instance
// sharing the same stimulus for the counter saturation case.
module tb_branch_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  prog_ctr;
    logic        br_valid;
    logic [1:0]  br_cond;
    logic [3:0]  br_idx;
    logic        flag_we;
    logic        zero_in;
    logic        neg_in;
    logic        lut_we;
    logic [3:0]  lut_waddr;
    logic [7:0]  lut_wdata;

    logic        branch, flush, halt;
    logic [7:0]  target;
    logic [15:0] taken_cnt;

    logic        branch2, flush2, halt2;
    logic [7:0]  target2;
    logic [1:0]  taken_cnt2;

    int passed;
    int total;

    branch_ctrl #(.D(8), .L(4), .C(16)) dut (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .br_valid(br_valid),
        .br_cond(br_cond), .br_idx(br_idx), .flag_we(flag_we), .zero_in(zero_in),
        .neg_in(neg_in), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .branch(branch), .target(target), .flush(flush), .halt(halt),
        .taken_cnt(taken_cnt)
    );

    branch_ctrl #(.D(8), .L(4), .C(2)) dut_sat (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .br_valid(br_valid),
        .br_cond(br_cond), .br_idx(br_idx), .flag_we(flag_we), .zero_in(zero_in),
        .neg_in(neg_in), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .branch(branch2), .target(target2), .flush(flush2), .halt(halt2),
        .taken_cnt(taken_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change and registers are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        prog_ctr  = 8'h00;
        br_valid  = 1'b0;
        br_cond   = 2'b00;
        br_idx    = 4'd0;
        flag_we   = 1'b0;
        zero_in   = 1'b0;
        neg_in    = 1'b0;
        lut_we    = 1'b0;
        lut_waddr = 4'd0;
        lut_wdata = 8'h00;

        // Reset state
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_flush",  32'(flush),     32'd0);
        check("rst_halt",   32'(halt),      32'd0);
        check("rst_cnt",    32'(taken_cnt), 32'd0);
        check("rst_branch", 32'(branch),    32'd0);
        check("rst_target", 32'(target),    32'h00);

        // 1: unconditional jump via LUT entry 3
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 8'h40;
        step();
        lut_we = 1'b0;
        br_valid = 1'b1; br_cond = 2'b00; br_idx = 4'd3; prog_ctr = 8'h05;
        #1;
        check("t1_branch", 32'(branch), 32'd1);
        check("t1_target", 32'(target), 32'h40);
        step();
        br_valid = 1'b0;
        #1;
        check("t1_flush", 32'(flush),     32'd1);
        check("t1_cnt",   32'(taken_cnt), 32'd1);
        step();
        check("t1_flush_clr", 32'(flush), 32'd0);

        // 2: zero-flag bypass takes br_cond=01, then registered zero blocks br_cond=10
        flag_we = 1'b1; zero_in = 1'b1;
        br_valid = 1'b1; br_cond = 2'b01; br_idx = 4'd3; prog_ctr = 8'h10;
        #1;
        check("t2_bypass_branch", 32'(branch), 32'd1);
        step();
        flag_we = 1'b0; zero_in = 1'b0; br_valid = 1'b0;
        #1;
        check("t2_flush", 32'(flush),     32'd1);
        check("t2_cnt",   32'(taken_cnt), 32'd2);
        step();
        br_valid = 1'b1; br_cond = 2'b10;
        #1;
        check("t2_nz_branch", 32'(branch), 32'd0);
        step();
        br_valid = 1'b0;
        #1;
        check("t2_nz_flush", 32'(flush),     32'd0);
        check("t2_nz_cnt",   32'(taken_cnt), 32'd2);

        // 3: branch immediately after a taken branch is squashed
        br_valid = 1'b1; br_cond = 2'b00; br_idx = 4'd3; prog_ctr = 8'h20;
        #1;
        check("t3_first_branch", 32'(branch), 32'd1);
        step();
        #1;
        check("t3_shadow_branch", 32'(branch),    32'd0);
        check("t3_shadow_flush",  32'(flush),     32'd1);
        check("t3_shadow_cnt",    32'(taken_cnt), 32'd3);
        step();
        br_valid = 1'b0;
        #1;
        check("t3_cnt_once", 32'(taken_cnt), 32'd3);
        check("t3_flush_clr", 32'(flush),    32'd0);

        // 4: LUT read-during-write returns old contents
        lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 8'h10;
        step();
        lut_wdata = 8'h20;
        br_valid = 1'b1; br_cond = 2'b00; br_idx = 4'd2; prog_ctr = 8'h30;
        #1;
        check("t4_rdw_branch", 32'(branch), 32'd1);
        check("t4_rdw_target", 32'(target), 32'h10);
        step();
        lut_we = 1'b0; br_valid = 1'b0;
        step();
        br_valid = 1'b1;
        #1;
        check("t4_new_target", 32'(target), 32'h20);
        step();
        br_valid = 1'b0;
        step();
        check("t4_cnt", 32'(taken_cnt), 32'd5);

        // 5: branch-to-self halts until reset
        lut_we = 1'b1; lut_waddr = 4'd1; lut_wdata = 8'h33;
        step();
        lut_we = 1'b0;
        br_valid = 1'b1; br_cond = 2'b00; br_idx = 4'd1; prog_ctr = 8'h33;
        #1;
        check("t5_halt_branch", 32'(branch), 32'd1);
        check("t5_halt_target", 32'(target), 32'h33);
        check("t5_halt_pre",    32'(halt),   32'd0);
        step();
        prog_ctr = 8'h50; br_idx = 4'd3;
        #1;
        check("t5_halt",        32'(halt),      32'd1);
        check("t5_flush",       32'(flush),     32'd1);
        check("t5_hold_branch", 32'(branch),    32'd1);
        check("t5_hold_target", 32'(target),    32'h50);
        check("t5_cnt",         32'(taken_cnt), 32'd6);
        step();
        step();
        check("t5_halt_stays", 32'(halt),      32'd1);
        check("t5_flush_stays", 32'(flush),    32'd1);
        check("t5_cnt_stays",  32'(taken_cnt), 32'd6);
        reset = 1'b1;
        #1;
        check("t5_rst_branch", 32'(branch), 32'd0);
        step();
        reset = 1'b0; br_valid = 1'b0;
        #1;
        check("t5_post_halt",  32'(halt),      32'd0);
        check("t5_post_flush", 32'(flush),     32'd0);
        check("t5_post_cnt",   32'(taken_cnt), 32'd0);
        br_idx = 4'd3;
        #1;
        check("t5_lut3_clr", 32'(target), 32'h00);
        br_idx = 4'd2;
        #1;
        check("t5_lut2_clr", 32'(target), 32'h00);
        br_idx = 4'd1;
        #1;
        check("t5_lut1_clr", 32'(target), 32'h00);

        // 6: 2-bit counter saturates at 3
        prog_ctr = 8'h80; br_idx = 4'd0; br_cond = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            br_valid = 1'b1;
            step();
            br_valid = 1'b0;
            #1;
            check($sformatf("t6_sat_cnt%0d", k), 32'(taken_cnt2), (k < 3) ? k : 3);
            check($sformatf("t6_wide_cnt%0d", k), 32'(taken_cnt), 32'(k));
            step();
        end
        check("t6_no_halt", 32'(halt2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Produces the `branch`/`target` pair consumed by the program counter.
- Resolves conditional branches from the decoded instruction against registered ALU flags, and looks up absolute jump targets in a programmable target LUT.
- Squashes the single wrong-path instruction after a taken branch.
- Detects branch-to-self as program halt.
- Sits between decode/ALU and the PC.

Parameters:
- D, 8, PC / target width (must match the PC's D)
- L, 4, target-LUT index width; LUT depth = 2**L
- C, 16, taken-branch counter width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- prog_ctr  input  D  current PC value from the PC
- br_valid  input  1  decoded instruction this cycle is a branch
- br_cond  input  2  condition code:
  - 00 = always
  - 01 = if zero
  - 10 = if not zero
  - 11 = if negative
- br_idx  input  L  target-LUT index for this branch
- flag_we  input  1  ALU flag update strobe
- zero_in  input  1  ALU zero flag
- neg_in  input  1  ALU negative flag
- lut_we  input  1  target-LUT write enable
- lut_waddr  input  L  target-LUT write index
- lut_wdata  input  D  target-LUT write data
- branch  output  1  to PC: load target at next posedge
- target  output  D  to PC: absolute jump target
- flush  output  1  registered: current fetched instruction is wrong-path, decode must treat it as a no-op
- halt  output  1  registered: program finished
- taken_cnt  output  C  number of taken branches since reset, saturating

Behaviour:
- **Reset** (clk edge with reset=1):
  - all LUT entries = 0
  - zero_f = 0, neg_f = 0
  - state = RUN
  - flush = 0, halt = 0, taken_cnt = 0
- **Reset during operation:** reset has priority over every other input in that cycle, including lut_we, flag_we and br_valid.
  - branch = 0 while reset = 1.
- **Flags:** zero_f/neg_f load zero_in/neg_in at a posedge when flag_we=1.
- **Flag bypass:** condition evaluation uses zero_in/neg_in when flag_we=1 in the same cycle, otherwise zero_f/neg_f.
- **Condition:**
  - cond_ok = (br_cond==00) | (br_cond==01 & z) | (br_cond==10 & ~z) | (br_cond==11 & n)
  - z and n are the bypassed flag values.
- **LUT read:** combinational, lut[br_idx].
- **LUT write:** lut[lut_waddr] <= lut_wdata at posedge when lut_we=1.
- **LUT read-during-write to the same index** returns the OLD contents; the new value is visible from the next cycle.
- **take** = br_valid & cond_ok & (state==RUN).
- **branch/target:** combinational, same cycle as br_valid, so the PC loads target at the next edge (zero added latency).
- **Idle outputs:** when not taking, branch=0 and target = lut[br_idx], a don't-care value for the PC but still deterministic.
- **FSM states:** RUN, SHADOW, HALT.
  - **RUN:**
    - take & lut[br_idx]==prog_ctr (branch-to-self) -> HALT.
    - take otherwise -> SHADOW.
    - Otherwise stay in RUN.
  - **SHADOW:** lasts exactly one cycle, then -> RUN.
    - flush=1 during this cycle.
    - br_valid is ignored: branch=0, no count, no flag-driven take. The instruction is wrong-path.
    - flag_we still updates the flags; the ALU gating is decode's responsibility.
  - **HALT:** terminal until reset.
    - halt=1, flush=1.
    - branch=1, target=prog_ctr, so the PC holds its value.
    - All br_valid is ignored.
- **Registered output timing:**
  - flush=1 exactly in the cycle following a taken branch, or every cycle in HALT.
  - halt=1 from the cycle after the halting branch.
- **taken_cnt:** increments by 1 at each posedge where take=1, including the halting branch; saturates at 2**C-1 with no wrap.
- **Back-to-back branches:** a branch in the cycle right after a taken branch is always squashed, never taken.
- **Width rule:** target is exactly D bits, with no sign extension and no relative arithmetic. Relative offsets are resolved by the assembler into LUT contents.

Test Plan:
1. **Reset then unconditional jump.**
   - Stimulus: reset 2 cycles; lut_we idx 3 <- 8'h40; then br_valid=1, br_cond=00, br_idx=3, prog_ctr=8'h05.
   - Required: branch=1 and target=8'h40 in that cycle; flush=1 the next cycle; taken_cnt=1.
2. **Conditional on flags, with bypass.**
   - Stimulus: flag_we=1 with zero_in=1 in the same cycle as br_cond=01.
   - Required: taken.
   - Stimulus: next, with zero_f=1, issue br_cond=10.
   - Required: branch=0, flush stays 0, taken_cnt unchanged.
3. **Shadow squash.**
   - Stimulus: taken branch in cycle N, br_valid=1 with br_cond=00 again in cycle N+1.
   - Required: branch=0 in N+1, flush=1 in N+1, taken_cnt increments only once.
4. **LUT read-during-write.**
   - Stimulus: lut[2]=8'h10; same cycle lut_we idx2 <- 8'h20 and taken branch idx2.
   - Required: target=8'h10.
   - Stimulus: next taken branch idx2.
   - Required: target=8'h20.
5. **Halt.**
   - Stimulus: lut[1]=8'h33, prog_ctr=8'h33, br_valid, br_cond=00, idx1.
   - Required: halt=1 and flush=1 from the next cycle onward, branch=1 with target=prog_ctr every cycle, further br_valid ignored.
   - Stimulus: then reset.
   - Required: halt=0, taken_cnt=0, LUT cleared.
6. **Counter saturation.**
   - Stimulus: C=2, 5 taken branches separated by idle cycles.
   - Required: taken_cnt sequence 1, 2, 3, 3, 3.
